// File: rtl/serial_frame_rx_if.sv
// Bus bundle for serial_frame_rx: serial line and strobe in, framed word and status out.
// master = the side that drives the serial line; slave = the receiver.
interface serial_frame_rx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             serIn;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             frameErr;
    logic             parityErr;
    logic             busy;

    modport master (
        output en,
        output serIn,
        input  dout,
        input  valid,
        input  frameErr,
        input  parityErr,
        input  busy
    );

    modport slave (
        input  en,
        input  serIn,
        output dout,
        output valid,
        output frameErr,
        output parityErr,
        output busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits LSB first,
// optional even-parity bit, stop bit. One serial bit is consumed per en strobe.
// Optional feature macro: PARITY_CHECK_EN (adds the parity bit and parityErr).
module serial_frame_rx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             C,
    input  logic             R,
    serial_frame_rx_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
`ifdef PARITY_CHECK_EN
        PARITY = 2'd2,
`endif
        STOP   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
`ifdef PARITY_CHECK_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    // Next-state and output decode; everything holds unless en samples the line.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef PARITY_CHECK_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (bus.serIn == 1'b0) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
                DATA: begin
                    // LSB arrives first, so bits enter at the top and walk down.
                    shift_d = {bus.serIn, shift_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    par_d   = bus.serIn;
                    state_d = STOP;
                end
`endif
                STOP: begin
                    if (bus.serIn == 1'b1) begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
                        // Even parity: data plus parity bit must hold an even count of ones.
                        perr_d  = ^{shift_q, par_q};
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge C) begin
        if (R) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef PARITY_CHECK_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.dout     = dout_q;
    assign bus.valid    = valid_q;
    assign bus.frameErr = ferr_q;
    assign bus.busy     = busy_q;
`ifdef PARITY_CHECK_EN
    assign bus.parityErr = perr_q;
`else
    assign bus.parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: queue-based frame model checked every cycle,
// plus directed frames with literal expectations.
module tb_serial_frame_rx;
    localparam int unsigned WIDTH = 8;
`ifdef PARITY_CHECK_EN
    localparam int unsigned FRAME_LEN = WIDTH + 3;
    localparam int          LATENCY   = 10;
`else
    localparam int unsigned FRAME_LEN = WIDTH + 2;
    localparam int          LATENCY   = 9;
`endif

    logic C;
    logic R;
    serial_frame_rx_if #(.WIDTH(WIDTH)) bus ();

    serial_frame_rx #(.WIDTH(WIDTH)) dut (
        .C   (C),
        .R   (R),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    logic [WIDTH-1:0] exp_dout  = '0;
    logic             exp_valid = 1'b0;
    logic             exp_ferr  = 1'b0;
    logic             exp_perr  = 1'b0;
    logic             exp_busy  = 1'b0;

    int n_valid = 0;
    int n_ferr  = 0;
    int n_perr  = 0;
    int last_valid_cyc = -1;
    int last_perr_cyc  = -2;

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: collect sampled bits of the current frame, judge the frame when complete.
    bit frame_q[$];
    initial begin
        int word;
        int ones;
        forever begin
            @(posedge C);
            cyc++;
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            exp_perr  = 1'b0;
            if (R === 1'b1) begin
                frame_q.delete();
                exp_dout = '0;
            end else if (bus.en === 1'b1) begin
                if (frame_q.size() != 0 || bus.serIn === 1'b0)
                    frame_q.push_back(bus.serIn);
                if (frame_q.size() == FRAME_LEN) begin
                    word = 0;
                    ones = 0;
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        if (frame_q[1 + i]) begin
                            word += (1 << i);
                            ones++;
                        end
                    end
                    if (frame_q[FRAME_LEN - 1]) begin
                        exp_dout  = WIDTH'(word);
                        exp_valid = 1'b1;
`ifdef PARITY_CHECK_EN
                        exp_perr  = ((ones + int'(frame_q[WIDTH + 1])) % 2) != 0;
`endif
                    end else begin
                        exp_ferr = 1'b1;
                    end
                    frame_q.delete();
                end
            end
            exp_busy = (frame_q.size() != 0);
        end
    end

    // Per-cycle compare against the model, plus pulse bookkeeping.
    initial begin
        forever begin
            @(negedge C);
            if (chk_en) begin
                chk("dout",      32'(bus.dout),      32'(exp_dout));
                chk("valid",     32'(bus.valid),     32'(exp_valid));
                chk("frameErr",  32'(bus.frameErr),  32'(exp_ferr));
                chk("parityErr", 32'(bus.parityErr), 32'(exp_perr));
                chk("busy",      32'(bus.busy),      32'(exp_busy));
                if (bus.valid === 1'b1) begin
                    n_valid++;
                    last_valid_cyc = cyc;
                end
                if (bus.frameErr === 1'b1) n_ferr++;
                if (bus.parityErr === 1'b1) begin
                    n_perr++;
                    last_perr_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic e, input logic s, input logic r);
        @(negedge C);
        R         = r;
        bus.en    = e;
        bus.serIn = s;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b1, 1'b0);
    endtask

    // Off-strobe cycles carry the inverted bit so gating by en is exercised.
    task automatic send_bit(input logic b, input int period);
        for (int k = 0; k < period - 1; k++) drive(1'b0, ~b, 1'b0);
        drive(1'b1, b, 1'b0);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] data, input logic stop_b,
                              input logic par_b, input int period, output int start_cyc);
        for (int k = 0; k < period - 1; k++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        start_cyc = cyc + 1;
        for (int i = 0; i < int'(WIDTH); i++) send_bit(data[i], period);
`ifdef PARITY_CHECK_EN
        send_bit(par_b, period);
`else
        if (par_b === 1'bx) start_cyc = start_cyc;
`endif
        send_bit(stop_b, period);
    endtask

    initial begin
        int s;
        int v0;
        int f0;
        int p0;
        R         = 1'b1;
        bus.en    = 1'b0;
        bus.serIn = 1'b1;

        // Reset for two cycles, then an idle line with en held high.
        drive(1'b0, 1'b1, 1'b1);
        chk_en = 1'b1;
        drive(1'b0, 1'b1, 1'b1);
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        idle(20);
        chk("idle_valid_pulses", 32'(n_valid - v0), 32'd0);
        chk("idle_ferr_pulses",  32'(n_ferr - f0),  32'd0);
        chk("idle_perr_pulses",  32'(n_perr - p0),  32'd0);
        chk("idle_dout",         32'(bus.dout),     32'h0);
        chk("idle_busy",         32'(bus.busy),     32'd0);

        // Good frame 0xA5, en tied high.
        v0 = n_valid;
        send_frame(8'hA5, 1'b1, ^8'hA5, 1, s);
        idle(3);
        chk("a5_dout",        32'(bus.dout),              32'h0000_00A5);
        chk("a5_valid_count", 32'(n_valid - v0),          32'd1);
        chk("a5_latency",     32'(last_valid_cyc - s),    32'(LATENCY));

        // Same frame with a low stop bit.
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hA5, 1'b0, ^8'hA5, 1, s);
        idle(3);
        chk("badstop_ferr_count",  32'(n_ferr - f0),  32'd1);
        chk("badstop_valid_count", 32'(n_valid - v0), 32'd0);
        chk("badstop_dout_kept",   32'(bus.dout),     32'h0000_00A5);

        // Strobed sampling, en every 4th cycle.
        v0 = n_valid;
        send_frame(8'h3C, 1'b1, ^8'h3C, 4, s);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        idle(3);
        chk("strobe_dout",        32'(bus.dout),     32'h0000_003C);
        chk("strobe_valid_count", 32'(n_valid - v0), 32'd1);

        // Reset after four data bits, then a clean 0x81 frame.
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        chk("rst_dout_cleared", 32'(bus.dout), 32'h0);
        chk("rst_busy_low",     32'(bus.busy), 32'd0);
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h81, 1'b1, ^8'h81, 1, s);
        idle(3);
        chk("rst_81_dout",        32'(bus.dout),     32'h0000_0081);
        chk("rst_81_ferr_count",  32'(n_ferr - f0),  32'd0);
        chk("rst_81_valid_count", 32'(n_valid - v0), 32'd1);

        // Back-to-back frames with no idle gap.
        v0 = n_valid;
        send_frame(8'h5A, 1'b1, ^8'h5A, 1, s);
        send_frame(8'hC3, 1'b1, ^8'hC3, 1, s);
        idle(3);
        chk("b2b_valid_count", 32'(n_valid - v0), 32'd2);
        chk("b2b_dout",        32'(bus.dout),     32'h0000_00C3);

`ifdef PARITY_CHECK_EN
        // 0x07 has three ones: parity bit 0 is wrong, 1 is right.
        v0 = n_valid; p0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b0, 1, s);
        idle(3);
        chk("par_bad_valid",     32'(n_valid - v0),                   32'd1);
        chk("par_bad_perr",      32'(n_perr - p0),                    32'd1);
        chk("par_bad_same_cyc",  32'(last_perr_cyc == last_valid_cyc), 32'd1);
        v0 = n_valid; p0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b1, 1, s);
        idle(3);
        chk("par_good_valid",    32'(n_valid - v0), 32'd1);
        chk("par_good_perr",     32'(n_perr - p0),  32'd0);
        chk("par_dout",          32'(bus.dout),     32'h0000_0007);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
